// File: rtl/dsp_lane_bank_if.sv
// dsp_lane_bank_if: operand/product bundle between the matrix compute engine
// (master) and the shared multiply bank (slave).
interface dsp_lane_bank_if #(
  parameter int LANES = 5,
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int OUT_W = 37
);
  logic                             dsp_ce;
  logic                             flush;
  logic [LANES-1:0][A_W-1:0]        dsp_a0;
  logic [LANES-1:0][B_W-1:0]        dsp_b0;
  logic [LANES-1:0][OUT_W-1:0]      dsp_out;
  logic                             out_valid;
  logic [15:0]                      mac_count;

  modport master (
    output dsp_ce, flush, dsp_a0, dsp_b0,
    input  dsp_out, out_valid, mac_count
  );

  modport slave (
    input  dsp_ce, flush, dsp_a0, dsp_b0,
    output dsp_out, out_valid, mac_count
  );
endinterface

// File: rtl/dsp_lane_bank.sv
// dsp_lane_bank: LANES independent CE-gated pipelined multipliers with a shared
// valid-token shift register, synchronous flush and a saturating CE counter.
// Optional feature macro: DSP_LANE_BANK_SIGNED_EN (signed operands, sign-extended
// product). Default build is unsigned with zero extension.

// One multiply lane: operand register, product register, then delay stages.
module dsp_lane #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int OUT_W = 37,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             flush,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [OUT_W-1:0] p
);
  localparam int PW = A_W + B_W;

  // Full-width product, extended to OUT_W (OUT_W > PW so the pad is never empty).
  function automatic logic [OUT_W-1:0] mul_ext(input logic [A_W-1:0] fa,
                                               input logic [B_W-1:0] fb);
    logic [PW-1:0] xa;
    logic [PW-1:0] xb;
    logic [PW-1:0] prod;
`ifdef DSP_LANE_BANK_SIGNED_EN
    // Low PW bits of a PW x PW product of sign-extended operands equal the
    // exact signed product, which always fits in PW bits.
    xa   = {{B_W{fa[A_W-1]}}, fa};
    xb   = {{A_W{fb[B_W-1]}}, fb};
    prod = xa * xb;
    return {{(OUT_W-PW){prod[PW-1]}}, prod};
`else
    xa   = {{B_W{1'b0}}, fa};
    xb   = {{A_W{1'b0}}, fb};
    prod = xa * xb;
    return {{(OUT_W-PW){1'b0}}, prod};
`endif
  endfunction

  if (PIPE == 1) begin : g_p1
    logic [OUT_W-1:0] p_q;
    // Single stage: live operands multiplied straight into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     p_q <= '0;
      else if (flush) p_q <= '0;
      else if (ce)    p_q <= mul_ext(a, b);
    end
    assign p = p_q;
  end else begin : g_pn
    logic [A_W-1:0]              a_r;
    logic [B_W-1:0]              b_r;
    logic [PIPE:2][OUT_W-1:0]    stg;
    // Operand capture, product register, then plain delay stages 3..PIPE.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_r <= '0;
        b_r <= '0;
        stg <= '0;
      end else if (flush) begin
        a_r <= '0;
        b_r <= '0;
        stg <= '0;
      end else if (ce) begin
        a_r    <= a;
        b_r    <= b;
        stg[2] <= mul_ext(a_r, b_r);
        for (int k = 3; k <= PIPE; k++) stg[k] <= stg[k-1];
      end
    end
    assign p = stg[PIPE];
  end
endmodule

module dsp_lane_bank #(
  parameter int LANES = 5,
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int OUT_W = 37,
  parameter int PIPE  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dsp_lane_bank_if.slave  bus
);
  if (PIPE < 1 || PIPE > 4) begin : g_bad_pipe
    $error("dsp_lane_bank: PIPE must be 1..4");
  end
  if (OUT_W < A_W + B_W + 1) begin : g_bad_outw
    $error("dsp_lane_bank: OUT_W must be >= A_W+B_W+1");
  end

  logic [PIPE:1]  vld_pipe;
  logic [PIPE:0]  vld_nxt;
  logic [15:0]    cnt_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dsp_lane #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .PIPE(PIPE)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (bus.dsp_ce),
      .flush (bus.flush),
      .a     (bus.dsp_a0[i]),
      .b     (bus.dsp_b0[i]),
      .p     (bus.dsp_out[i])
    );
  end

  // A 1 enters the token chain on every CE edge; the last bit marks a real product.
  assign vld_nxt = {vld_pipe, 1'b1};

  // Token shift register, moves in lockstep with the data stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            vld_pipe <= '0;
    else if (bus.flush)    vld_pipe <= '0;
    else if (bus.dsp_ce)   vld_pipe <= vld_nxt[PIPE-1:0];
  end

  // CE-cycle activity counter, saturating at all-ones; flush takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               cnt_q <= '0;
    else if (bus.flush)                       cnt_q <= '0;
    else if (bus.dsp_ce && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign bus.out_valid = vld_pipe[PIPE];
  assign bus.mac_count = cnt_q;
endmodule
